// File: rtl/spi_enet_burst_ctrl.sv
// Burst sequencer for the SPI master register port: selects a slave, asserts SSO,
// moves one byte at a time through TXDATA/RXDATA, then drops SSO.
module spi_enet_burst_ctrl #(
  parameter int LEN_W      = 12,
  parameter int NUM_SLAVES = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [LEN_W-1:0]      cmd_len,
  input  logic [NUM_SLAVES-1:0] cmd_slave,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  input  logic [7:0]            tx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic [7:0]            rx_data,
  output logic                  done,
  output logic                  spi_select,
  output logic [2:0]            spi_addr,
  output logic [15:0]           spi_wdata,
  output logic                  spi_read_n,
  output logic                  spi_write_n,
  input  logic [15:0]           spi_rdata,
  input  logic                  spi_readyfordata,
  input  logic                  spi_dataavailable
);

  typedef enum logic [3:0] {
    S_IDLE, S_SS_WR, S_CTL_ON, S_WAIT_T, S_DAT_WR,
    S_WAIT_R, S_DAT_RD, S_RX_OUT, S_CTL_OFF, S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [1:0]            ph_q, ph_d;
  logic [LEN_W-1:0]      rem_q, rem_d;
  logic [NUM_SLAVES-1:0] slave_q, slave_d;
  logic [7:0]            txb_q, txb_d, rxb_q, rxb_d;

  logic        acc_en, acc_rd, acc_act;
  logic [2:0]  acc_addr;
  logic [15:0] acc_wdata;
  logic        unused_rdata_hi;

  assign unused_rdata_hi = ^spi_rdata[15:8];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      ph_q    <= '0;
      rem_q   <= '0;
      slave_q <= '0;
      txb_q   <= '0;
      rxb_q   <= '0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      rem_q   <= rem_d;
      slave_q <= slave_d;
      txb_q   <= txb_d;
      rxb_q   <= rxb_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ph_d      = '0;
    rem_d     = rem_q;
    slave_d   = slave_q;
    txb_d     = txb_q;
    rxb_d     = rxb_q;
    cmd_ready = 1'b0;
    tx_ready  = 1'b0;
    rx_valid  = 1'b0;
    done      = 1'b0;
    acc_en    = 1'b0;
    acc_rd    = 1'b0;
    acc_addr  = 3'd0;
    acc_wdata = 16'h0000;
    unique case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          rem_d   = cmd_len;
          slave_d = cmd_slave;
          state_d = (cmd_len == '0) ? S_DONE : S_SS_WR;
        end
      end
      S_SS_WR: begin
        acc_en    = 1'b1;
        acc_addr  = 3'd5;
        acc_wdata = 16'(slave_q);
        if (ph_q == 2'd2) state_d = S_CTL_ON;
      end
      S_CTL_ON: begin
        acc_en    = 1'b1;
        acc_addr  = 3'd3;
        acc_wdata = 16'h0400;
        if (ph_q == 2'd2) state_d = S_WAIT_T;
      end
      S_WAIT_T: begin
        if (spi_readyfordata && tx_valid) begin
          tx_ready = 1'b1;
          txb_d    = tx_data;
          state_d  = S_DAT_WR;
        end
      end
      S_DAT_WR: begin
        acc_en    = 1'b1;
        acc_addr  = 3'd1;
        acc_wdata = {8'h00, txb_q};
        if (ph_q == 2'd2) state_d = S_WAIT_R;
      end
      S_WAIT_R: begin
        if (spi_dataavailable) state_d = S_DAT_RD;
      end
      S_DAT_RD: begin
        acc_en   = 1'b1;
        acc_rd   = 1'b1;
        acc_addr = 3'd0;
        // last strobe cycle: core data is valid on this edge
        if (ph_q == 2'd1) rxb_d = spi_rdata[7:0];
        if (ph_q == 2'd2) state_d = S_RX_OUT;
      end
      S_RX_OUT: begin
        rx_valid = 1'b1;
        if (rx_ready) begin
          rem_d   = rem_q - LEN_W'(1);
          state_d = (rem_q == LEN_W'(1)) ? S_CTL_OFF : S_WAIT_T;
        end
      end
      S_CTL_OFF: begin
        acc_en    = 1'b1;
        acc_addr  = 3'd3;
        acc_wdata = 16'h0000;
        if (ph_q == 2'd2) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // phases 0,1 strobe the core, phase 2 is the idle gap
    if (acc_en) ph_d = (ph_q == 2'd2) ? 2'd0 : ph_q + 2'd1;
  end

  assign acc_act     = acc_en && (ph_q != 2'd2);
  assign spi_select  = acc_act;
  assign spi_addr    = acc_act ? acc_addr : 3'd0;
  assign spi_wdata   = acc_act ? acc_wdata : 16'h0000;
  assign spi_read_n  = !(acc_act && acc_rd);
  assign spi_write_n = !(acc_act && !acc_rd);
  assign rx_data     = rxb_q;

endmodule

// File: tb/tb_spi_enet_burst_ctrl.sv
// Directed bench for spi_enet_burst_ctrl with a small SPI-core register model.
module tb_spi_enet_burst_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [11:0] cmd_len;
  logic [0:0]  cmd_slave;
  logic        tx_valid, tx_ready;
  logic [7:0]  tx_data;
  logic        rx_valid, rx_ready;
  logic [7:0]  rx_data;
  logic        done;
  logic        spi_select;
  logic [2:0]  spi_addr;
  logic [15:0] spi_wdata;
  logic        spi_read_n, spi_write_n;
  logic [15:0] spi_rdata;
  logic        spi_readyfordata, spi_dataavailable;

  always #5 clk = ~clk;

  spi_enet_burst_ctrl #(.LEN_W(12), .NUM_SLAVES(1)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len), .cmd_slave(cmd_slave),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
    .done(done),
    .spi_select(spi_select), .spi_addr(spi_addr), .spi_wdata(spi_wdata),
    .spi_read_n(spi_read_n), .spi_write_n(spi_write_n), .spi_rdata(spi_rdata),
    .spi_readyfordata(spi_readyfordata), .spi_dataavailable(spi_dataavailable)
  );

  // stimulus-side state (written only by the initial block)
  logic       tx_en = 1'b1;
  logic       rfd = 1'b1;
  logic       loop_mode = 1'b1;
  logic [7:0] fixed_val = 8'h00;
  logic [7:0] tx_mem [0:255];
  int         tx_n = 0;
  int         checks = 0;
  int         errors = 0;

  // monitor / core-model state (written only by the negedge block)
  int          cyc = 0, run = 0, nacc = 0, n_wr1 = 0, n_ctl = 0;
  int          tx_idx = 0, tx_cnt = 0, rx_cnt = 0, done_cnt = 0, sel_cyc = 0;
  int          cmd_acc = 0, acc_cyc = 0, done_cyc = 0, unstable = 0, da_cnt = 0;
  logic [19:0] acc_rec [0:255];
  int          acc_len [0:255];
  logic [7:0]  rx_got  [0:255];
  logic        tx_pend = 1'b0, stall_q = 1'b0, strobe = 1'b0, da = 1'b0;
  logic [7:0]  stall_d = 8'h00, pend_rx = 8'h00, rdata_b = 8'h00;

  assign tx_valid          = tx_en && (tx_idx < tx_n);
  assign tx_data           = tx_mem[tx_idx[7:0]];
  assign spi_readyfordata  = rfd;
  assign spi_dataavailable = da;
  assign spi_rdata         = {8'h00, rdata_b};

  always @(negedge clk) begin
    cyc++;
    if (tx_pend) tx_idx++;
    tx_pend = 1'b0;
    if (!reset_n) begin
      run = 0; da = 1'b0; da_cnt = 0; stall_q = 1'b0;
    end else begin
      tx_pend = tx_ready && tx_valid;
      if (tx_pend) tx_cnt++;
      if (rx_valid && rx_ready) begin rx_got[rx_cnt] = rx_data; rx_cnt++; end
      if (stall_q && rx_valid && rx_data !== stall_d) unstable++;
      stall_q = rx_valid && !rx_ready;
      stall_d = rx_data;
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (cmd_valid && cmd_ready) begin cmd_acc++; acc_cyc = cyc; end
      if (spi_select) sel_cyc++;
      if (da_cnt != 0) begin
        da_cnt--;
        if (da_cnt == 0) begin da = 1'b1; rdata_b = loop_mode ? pend_rx : fixed_val; end
      end
      strobe = spi_select && (!spi_write_n || !spi_read_n);
      if (strobe) begin
        if (run == 0) begin
          acc_rec[nacc] = {!spi_read_n, spi_addr, spi_wdata};
          nacc++;
          if (!spi_write_n && spi_addr == 3'd1) begin n_wr1++; da_cnt = 3; pend_rx = spi_wdata[7:0]; end
          if (!spi_write_n && spi_addr == 3'd3) n_ctl++;
          if (!spi_read_n) da = 1'b0;
        end
        run++;
      end else if (run != 0) begin
        acc_len[nacc-1] = run;
        run = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_tx(input logic [7:0] b);
    tx_mem[tx_n] = b;
    tx_n++;
  endtask

  task automatic issue_cmd(input logic [11:0] len);
    cmd_valid = 1'b1; cmd_len = len; cmd_slave = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int d0, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin @(negedge clk); #1; ok = (done_cnt > d0); end
    chk(tag, ok, 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  logic [19:0] e1 [0:4];
  int b, r0, d0, t0, w, a0, s0, u0;
  bit ok;

  initial begin
    e1[0] = 20'h50001; e1[1] = 20'h30400; e1[2] = 20'h100A5; e1[3] = 20'h80000; e1[4] = 20'h30000;
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_len = '0; cmd_slave = 1'b1; rx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_tx_ready", tx_ready, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_done", done, 0);
    chk("rst_bus", {spi_select, spi_addr, spi_wdata, spi_read_n, spi_write_n}, 22'h3);
    @(posedge clk); #1 reset_n = 1'b1;
    @(posedge clk); #1;

    // single byte, fixed response
    loop_mode = 1'b0; fixed_val = 8'h3C; push_tx(8'hA5);
    b = nacc; r0 = rx_cnt; d0 = done_cnt;
    issue_cmd(12'd1);
    wait_done(d0, "t1_done_seen");
    chk("t1_nacc", nacc - b, 5);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t1_acc%0d", k), acc_rec[b+k], e1[k]);
      chk($sformatf("t1_len%0d", k), acc_len[b+k], 2);
    end
    chk("t1_rx_cnt", rx_cnt - r0, 1);
    chk("t1_rx_byte", rx_got[r0], 8'h3C);
    chk("t1_done_once", done_cnt - d0, 1);

    // four bytes, loopback
    loop_mode = 1'b1;
    push_tx(8'h01); push_tx(8'h02); push_tx(8'h03); push_tx(8'h04);
    b = nacc; r0 = rx_cnt; d0 = done_cnt; t0 = tx_cnt; w = n_ctl;
    issue_cmd(12'd4);
    wait_done(d0, "t2_done_seen");
    chk("t2_nacc", nacc - b, 11);
    chk("t2_ctl_writes", n_ctl - w, 2);
    chk("t2_tx_hs", tx_cnt - t0, 4);
    chk("t2_rx_hs", rx_cnt - r0, 4);
    for (int k = 0; k < 4; k++) chk($sformatf("t2_rx%0d", k), rx_got[r0+k], k + 1);

    // zero length: no bus traffic
    s0 = sel_cyc; d0 = done_cnt;
    issue_cmd(12'd0);
    wait_done(d0, "t3_done_seen");
    chk("t3_done_latency", done_cyc - acc_cyc, 1);
    chk("t3_no_select", sel_cyc - s0, 0);
    chk("t3_done_once", done_cnt - d0, 1);

    // RX consumer stall on byte 2
    push_tx(8'h11); push_tx(8'h22); push_tx(8'h33);
    r0 = rx_cnt; d0 = done_cnt; u0 = unstable;
    issue_cmd(12'd3);
    ok = 1'b0;
    for (int i = 0; i < 500 && !ok; i++) begin @(negedge clk); #1; ok = (rx_cnt > r0); end
    chk("t4_rx1_seen", ok, 1);
    @(posedge clk); #1 rx_ready = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 500 && !ok; i++) begin @(negedge clk); #1; ok = rx_valid; end
    chk("t4_rx2_valid", ok, 1);
    w = n_wr1;
    repeat (20) @(negedge clk);
    #1;
    chk("t4_hold_valid", rx_valid, 1);
    chk("t4_hold_data", rx_data, 8'h22);
    chk("t4_no_wr1", n_wr1 - w, 0);
    chk("t4_stable", unstable - u0, 0);
    @(posedge clk); #1 rx_ready = 1'b1;
    wait_done(d0, "t4_done_seen");
    chk("t4_rx_hs", rx_cnt - r0, 3);
    chk("t4_rx0", rx_got[r0], 8'h11);
    chk("t4_rx1", rx_got[r0+1], 8'h22);
    chk("t4_rx2", rx_got[r0+2], 8'h33);

    // TX source stall, readyfordata toggling, command while busy
    tx_en = 1'b0; rfd = 1'b0;
    push_tx(8'h5A); push_tx(8'hC3);
    b = nacc; r0 = rx_cnt; d0 = done_cnt; a0 = cmd_acc;
    issue_cmd(12'd2);
    a0 = cmd_acc; t0 = tx_cnt; w = n_wr1;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      rfd = i[0];
      if (i == 5) begin cmd_valid = 1'b1; cmd_len = 12'd7; end
      if (i == 9) cmd_valid = 1'b0;
    end
    @(posedge clk); #1 rfd = 1'b0; tx_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("t5_no_wr1", n_wr1 - w, 0);
    chk("t5_no_tx_hs", tx_cnt - t0, 0);
    chk("t5_busy_reject", cmd_acc - a0, 0);
    rfd = 1'b1;
    wait_done(d0, "t5_done_seen");
    chk("t5_nacc", nacc - b, 7);
    chk("t5_rx0", rx_got[r0], 8'h5A);
    chk("t5_rx1", rx_got[r0+1], 8'hC3);
    chk("t5_accepts", cmd_acc - a0, 0);

    // reset during DAT_WR of byte 2 of 5
    push_tx(8'h61); push_tx(8'h62); push_tx(8'h63); push_tx(8'h64); push_tx(8'h65);
    w = n_wr1;
    issue_cmd(12'd5);
    ok = 1'b0;
    for (int i = 0; i < 500 && !ok; i++) begin @(negedge clk); #1; ok = (n_wr1 >= w + 2); end
    chk("t6_byte2_wr", ok, 1);
    reset_n = 1'b0;
    #1;
    chk("t6_bus", {spi_select, spi_addr, spi_wdata, spi_read_n, spi_write_n}, 22'h3);
    chk("t6_cmd_ready", cmd_ready, 1);
    chk("t6_rx_valid", rx_valid, 0);
    chk("t6_rx_data", rx_data, 0);
    chk("t6_tx_ready", tx_ready, 0);
    chk("t6_done", done, 0);
    b = nacc;
    repeat (10) @(posedge clk);
    #1;
    chk("t6_no_access", nacc - b, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    b = nacc; r0 = rx_cnt; d0 = done_cnt;
    issue_cmd(12'd2);
    wait_done(d0, "t6_done_seen");
    chk("t6_first_acc", acc_rec[b], 20'h50001);
    chk("t6_nacc", nacc - b, 7);
    chk("t6_rx0", rx_got[r0], 8'h63);
    chk("t6_rx1", rx_got[r0+1], 8'h64);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
